// File: rtl/clock_pkg.sv
// Shared types and constants for the digital-clock alarm path.
package clock_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    RING   = 2'd1,
    SNOOZE = 2'd2
  } ring_state_t;

  typedef logic [3:0] bcd_digit_t;

  localparam int unsigned SEC_PER_MIN = 60;

  function automatic logic bcd_pair_is_zero(input bcd_digit_t tens, input bcd_digit_t ones);
    return (tens == 4'd0) && (ones == 4'd0);
  endfunction

endpackage

// File: rtl/bcd_time_match.sv
// Combinational hh:mm equality against a reference time, qualified by seconds == 00.
module bcd_time_match
  import clock_pkg::*;
(
  input  bcd_digit_t now_hour_tens,
  input  bcd_digit_t now_hour_ones,
  input  bcd_digit_t now_minute_tens,
  input  bcd_digit_t now_minute_ones,
  input  bcd_digit_t now_second_tens,
  input  bcd_digit_t now_second_ones,
  input  bcd_digit_t ref_hour_tens,
  input  bcd_digit_t ref_hour_ones,
  input  bcd_digit_t ref_minute_tens,
  input  bcd_digit_t ref_minute_ones,
  output logic       match
);

  logic hm_equal_s;

  assign hm_equal_s = (now_hour_tens   == ref_hour_tens)   &&
                      (now_hour_ones   == ref_hour_ones)   &&
                      (now_minute_tens == ref_minute_tens) &&
                      (now_minute_ones == ref_minute_ones);

  assign match = hm_equal_s && bcd_pair_is_zero(now_second_tens, now_second_ones);

endmodule

// File: rtl/alarm_ring_ctrl.sv
// Alarm ring / snooze / stop sequencer driving the buzzer and status LEDs.
// Optional build macro HOURLY_CHIME_EN adds a one-second chime at each xx:00:00.
module alarm_ring_ctrl
  import clock_pkg::*;
#(
  parameter int unsigned RING_SECONDS = 60,
  parameter int unsigned SNOOZE_MIN   = 5,
  parameter int unsigned MAX_SNOOZE   = 3
) (
  input  logic       clk,
  input  logic       CLR_n,
  input  logic       sec_tick,
  input  logic [3:0] time_hour_tens,
  input  logic [3:0] time_hour_ones,
  input  logic [3:0] time_minute_tens,
  input  logic [3:0] time_minute_ones,
  input  logic [3:0] time_second_tens,
  input  logic [3:0] time_second_ones,
  input  logic [3:0] alarm_hour_tens,
  input  logic [3:0] alarm_hour_ones,
  input  logic [3:0] alarm_minute_setting_tens,
  input  logic [3:0] alarm_minute_setting_ones,
  input  logic       alarm_en,
  input  logic       isSettingAlarm,
  input  logic       snooze_pulse,
  input  logic       stop_pulse,
  output logic       buzzer,
  output logic       ringing,
  output logic       snoozing
);

  localparam logic [9:0] SZ_RELOAD = 10'(SNOOZE_MIN * SEC_PER_MIN - 1);
  localparam logic [7:0] RING_LAST = 8'(RING_SECONDS - 1);
  localparam logic [7:0] SNZ_LIMIT = 8'(MAX_SNOOZE);

  ring_state_t state_r;
  logic [7:0]  ring_cnt_r;
  logic [7:0]  snooze_cnt_r;
  logic [9:0]  sz_timer_r;
  logic        time_match_s;
  logic        match_s;
  logic        match_r;
  logic        trigger_s;

  bcd_time_match u_alarm_match (
    .now_hour_tens   (time_hour_tens),
    .now_hour_ones   (time_hour_ones),
    .now_minute_tens (time_minute_tens),
    .now_minute_ones (time_minute_ones),
    .now_second_tens (time_second_tens),
    .now_second_ones (time_second_ones),
    .ref_hour_tens   (alarm_hour_tens),
    .ref_hour_ones   (alarm_hour_ones),
    .ref_minute_tens (alarm_minute_setting_tens),
    .ref_minute_ones (alarm_minute_setting_ones),
    .match           (time_match_s)
  );

  // Edge-detecting the match keeps the alarm from re-firing within its minute after a stop.
  assign match_s   = time_match_s & alarm_en & ~isSettingAlarm;
  assign trigger_s = match_s & ~match_r;

`ifdef HOURLY_CHIME_EN
  logic        hour_top_s;
  logic        ms_changed_s;
  logic        chime_start_s;
  logic [15:0] prev_ms_r;

  bcd_time_match u_chime_match (
    .now_hour_tens   (time_hour_tens),
    .now_hour_ones   (time_hour_ones),
    .now_minute_tens (time_minute_tens),
    .now_minute_ones (time_minute_ones),
    .now_second_tens (time_second_tens),
    .now_second_ones (time_second_ones),
    .ref_hour_tens   (time_hour_tens),
    .ref_hour_ones   (time_hour_ones),
    .ref_minute_tens (4'd0),
    .ref_minute_ones (4'd0),
    .match           (hour_top_s)
  );

  assign ms_changed_s  = {time_minute_tens, time_minute_ones, time_second_tens, time_second_ones} != prev_ms_r;
  assign chime_start_s = hour_top_s & ms_changed_s;

  // Previous minute/second digits, used to detect the instant the time lands on xx:00:00.
  always_ff @(posedge clk or negedge CLR_n) begin
    if (!CLR_n) begin
      prev_ms_r <= 16'd0;
    end else begin
      prev_ms_r <= {time_minute_tens, time_minute_ones, time_second_tens, time_second_ones};
    end
  end
`endif

  // Alarm sequencer: state, counters and registered outputs.
  always_ff @(posedge clk or negedge CLR_n) begin
    if (!CLR_n) begin
      state_r      <= IDLE;
      ring_cnt_r   <= 8'd0;
      snooze_cnt_r <= 8'd0;
      sz_timer_r   <= 10'd0;
      match_r      <= 1'b0;
      buzzer       <= 1'b0;
      ringing      <= 1'b0;
      snoozing     <= 1'b0;
    end else begin
      match_r <= match_s;
      case (state_r)
        IDLE: begin
          if (trigger_s) begin
            state_r      <= RING;
            ring_cnt_r   <= 8'd0;
            snooze_cnt_r <= 8'd0;
            buzzer       <= 1'b1;
            ringing      <= 1'b1;
            snoozing     <= 1'b0;
          end else begin
`ifdef HOURLY_CHIME_EN
            if (chime_start_s) begin
              buzzer <= 1'b1;
            end else if (sec_tick) begin
              buzzer <= 1'b0;
            end else begin
              buzzer <= buzzer;
            end
`else
            buzzer <= 1'b0;
`endif
            ringing  <= 1'b0;
            snoozing <= 1'b0;
          end
        end
        RING: begin
          if (!alarm_en || stop_pulse) begin
            state_r <= IDLE;
            buzzer  <= 1'b0;
            ringing <= 1'b0;
          end else if (snooze_pulse) begin
            buzzer  <= 1'b0;
            ringing <= 1'b0;
            if (snooze_cnt_r < SNZ_LIMIT) begin
              state_r      <= SNOOZE;
              snooze_cnt_r <= snooze_cnt_r + 8'd1;
              sz_timer_r   <= SZ_RELOAD;
              snoozing     <= 1'b1;
            end else begin
              state_r <= IDLE;
            end
          end else if (sec_tick) begin
            if (ring_cnt_r == RING_LAST) begin
              state_r <= IDLE;
              buzzer  <= 1'b0;
              ringing <= 1'b0;
            end else begin
              ring_cnt_r <= ring_cnt_r + 8'd1;
              buzzer     <= ~buzzer;
            end
          end else begin
            state_r <= RING;
          end
        end
        SNOOZE: begin
          if (!alarm_en || stop_pulse) begin
            state_r  <= IDLE;
            buzzer   <= 1'b0;
            snoozing <= 1'b0;
          end else if (sec_tick) begin
            if (sz_timer_r == 10'd0) begin
              state_r    <= RING;
              ring_cnt_r <= 8'd0;
              buzzer     <= 1'b1;
              ringing    <= 1'b1;
              snoozing   <= 1'b0;
            end else begin
              sz_timer_r <= sz_timer_r - 10'd1;
            end
          end else begin
            state_r <= SNOOZE;
          end
        end
        default: begin
          state_r  <= IDLE;
          buzzer   <= 1'b0;
          ringing  <= 1'b0;
          snoozing <= 1'b0;
        end
      endcase
    end
  end

endmodule
